rem_seq_ctrl: RTL and testbench
===============================

Name: rem_seq_ctrl

Overview:
Sequential front-end for the combinational `rem` remainder unit. It accepts numerator then denominator as two 3-bit words over a valid/ready input stream and drives them, registered, into `rem`. It captures `rem`'s remainder and div-by-zero flag and presents them on a valid/ready output with backpressure. It also keeps a saturating count of divide-by-zero events for the calculator status display.

Parameters:
WIDTH, 3, operand/result width; must match `rem` (3).
ERRCNT_W, 4, width of the divide-by-zero event counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
abort  input  1  synchronous flush: drop the in-progress operation.
in_valid  input  1  in_data valid.
in_ready  output  1  block can accept in_data.
in_data  input  WIDTH  operand word: numerator first, then denominator.
rem_numerator  output  WIDTH  registered numerator to `rem`.
rem_denominator  output  WIDTH  registered denominator to `rem`.
rem_remainder  input  WIDTH  remainder from `rem`.
rem_divbyzero  input  1  divide-by-zero flag from `rem`.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
out_remainder  output  WIDTH  captured remainder.
out_divbyzero  output  1  captured divide-by-zero flag.
dbz_count  output  ERRCNT_W  saturating divide-by-zero event count.
selfcheck_err  output  1  sticky mismatch flag; only meaningful with REM_SELFCHECK_EN.

Behaviour:
- Reset and abort are synchronous. Priority: rst > abort > normal operation.
- States:
  - S_NUM: in_ready=1. On in_valid&in_ready, num_q<=in_data; go to S_DEN.
  - S_DEN: in_ready=1. On handshake, den_q<=in_data; go to S_EVAL.
  - S_EVAL: in_ready=0, lasts exactly 1 cycle. out_remainder<=rem_remainder; out_divbyzero<=rem_divbyzero. If rem_divbyzero=1, dbz_count increments. Go to S_OUT.
  - S_OUT: out_valid=1, in_ready=0. On out_ready, go to S_NUM; out_valid drops the next cycle.
- in_ready and out_valid are decoded from the state register only, never from same-cycle inputs. With rst=1, in_ready=0.
- rem_numerator=num_q and rem_denominator=den_q, held continuously; they change only on accepting handshakes.
- Latency: denominator accepted on edge N; `rem` outputs sampled on edge N+1; out_valid is high after edge N+1 (first S_OUT cycle).
- While out_valid=1 and out_ready=0: out_remainder, out_divbyzero and out_valid hold stable indefinitely; in_data is not accepted.
- The S_OUT->S_NUM transition takes one cycle. A numerator is never accepted in the same cycle as the result handshake.
- Divide-by-zero (den[1:0]=0, i.e. 3'b000 or 3'b100): `rem`'s outputs pass through unmodified. `rem` guarantees flag=1 and remainder[2]=numerator[2]. No special handling here.
- dbz_count saturates at 2^ERRCNT_W-1. It is cleared only by rst, not by abort.
- abort in any state: go to S_NUM, out_valid=0. num_q, den_q, out_remainder and out_divbyzero keep their values. dbz_count is unchanged. abort in S_EVAL suppresses the capture and the count update.
- Reset values: state S_NUM, num_q=0, den_q=0, out_remainder=0, out_divbyzero=0, out_valid=0, dbz_count=0, selfcheck_err=0.

Optional Feature:
Macro REM_SELFCHECK_EN.
- Defined: in S_EVAL, when den_q[1:0]!=0, compare rem_remainder[1:0] against num_q[1:0]%den_q[1:0]. On mismatch, set selfcheck_err (sticky; cleared by rst only; abort in S_EVAL suppresses the check).
- Undefined: no comparator is synthesized; selfcheck_err is tied 0.

Test Plan:
1. Basic: send num 3'b111, then den 3'b010, out_ready=1. Expect out_valid high after edge N+1, out_remainder[1:0]=2'b01, out_divbyzero=0, dbz_count=0.
2. Divide-by-zero: num 3'b101, den 3'b100. Expect out_divbyzero=1, out_remainder[2]=1, dbz_count=1.
3. Backpressure: after a result, hold out_ready=0 for 5 cycles while in_valid=1 with in_data=3'b011. Expect out_valid held, outputs stable, in_ready=0, no operand accepted. Then out_ready=1 for 1 cycle; expect S_NUM and in_ready=1 the next cycle.
4. Abort: accept num 3'b110, assert abort in S_DEN. Expect in_ready=1 (S_NUM), no out_valid, dbz_count unchanged. The next pair 3'b011/3'b010 gives remainder 2'b01.
5. Saturation: ERRCNT_W=4, run 17 divide-by-zero operations. Expect dbz_count=15 after the 15th and still 15 after the 17th.
6. Reset mid-operation: assert rst for 1 cycle in S_OUT. Expect out_valid=0, dbz_count=0, rem_numerator=0 and rem_denominator=0 the next cycle; in_ready=0 during rst and 1 after. With REM_SELFCHECK_EN, force rem_remainder wrong on one op: selfcheck_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/rem_seq_ctrl.sv
// Sequential operand/result front-end for the combinational rem unit.
// Optional REM_SELFCHECK_EN adds a sticky comparator on rem's low remainder bits.
module rem_seq_ctrl #(
  parameter int WIDTH    = 3,
  parameter int ERRCNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic [WIDTH-1:0]    rem_numerator,
  output logic [WIDTH-1:0]    rem_denominator,
  input  logic [WIDTH-1:0]    rem_remainder,
  input  logic                rem_divbyzero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_remainder,
  output logic                out_divbyzero,
  output logic [ERRCNT_W-1:0] dbz_count,
  output logic                selfcheck_err
);

  typedef enum logic [1:0] {
    S_NUM,
    S_DEN,
    S_EVAL,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]    num_q;
  logic [WIDTH-1:0]    den_q;
  logic [WIDTH-1:0]    res_q;
  logic                dbz_q;
  logic [ERRCNT_W-1:0] cnt_q;

  logic accept_num;
  logic accept_den;
  logic capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_NUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NUM:   if (in_valid)  state_d = S_DEN;
      S_DEN:   if (in_valid)  state_d = S_EVAL;
      S_EVAL:                 state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_NUM;
      default:                state_d = S_NUM;
    endcase
    if (abort) begin
      state_d = S_NUM;
    end
  end

  // Abort outranks every data update, so handshakes coinciding with it are dropped.
  assign accept_num = (state_q == S_NUM)  && in_valid && !abort;
  assign accept_den = (state_q == S_DEN)  && in_valid && !abort;
  assign capture    = (state_q == S_EVAL) && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q <= '0;
      den_q <= '0;
      res_q <= '0;
      dbz_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept_num) begin
        num_q <= in_data;
      end
      if (accept_den) begin
        den_q <= in_data;
      end
      if (capture) begin
        res_q <= rem_remainder;
        dbz_q <= rem_divbyzero;
        if (rem_divbyzero && (cnt_q != {ERRCNT_W{1'b1}})) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef REM_SELFCHECK_EN
  logic       chk_q;
  logic [1:0] expect_lo;

  assign expect_lo = (den_q[1:0] != 2'b00) ? (num_q[1:0] % den_q[1:0]) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= 1'b0;
    end else if (capture && (den_q[1:0] != 2'b00) && (rem_remainder[1:0] != expect_lo)) begin
      chk_q <= 1'b1;
    end
  end

  assign selfcheck_err = chk_q;
`else
  assign selfcheck_err = 1'b0;
`endif

  assign in_ready        = !rst && ((state_q == S_NUM) || (state_q == S_DEN));
  assign out_valid       = (state_q == S_OUT);
  assign rem_numerator   = num_q;
  assign rem_denominator = den_q;
  assign out_remainder   = res_q;
  assign out_divbyzero   = dbz_q;
  assign dbz_count       = cnt_q;

endmodule

// File: tb/tb_rem_seq_ctrl.sv
// Directed self-checking bench for rem_seq_ctrl with a behavioural stand-in for rem.
// Selfcheck steps are included when REM_SELFCHECK_EN is defined.
module tb_rem_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic [2:0] rem_numerator;
  logic [2:0] rem_denominator;
  logic [2:0] rem_remainder;
  logic       rem_divbyzero;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_remainder;
  logic       out_divbyzero;
  logic [3:0] dbz_count;
  logic       selfcheck_err;

  logic       corrupt;
  int         checks;
  int         errors;
  int         expCount;

  rem_seq_ctrl #(.WIDTH(3), .ERRCNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .abort           (abort),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .rem_numerator   (rem_numerator),
    .rem_denominator (rem_denominator),
    .rem_remainder   (rem_remainder),
    .rem_divbyzero   (rem_divbyzero),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_remainder   (out_remainder),
    .out_divbyzero   (out_divbyzero),
    .dbz_count       (dbz_count),
    .selfcheck_err   (selfcheck_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for rem: sign bit passes through, low bits are num%den, zero low den flags div-by-zero.
  always_comb begin
    rem_divbyzero = (rem_denominator[1:0] == 2'b00);
    rem_remainder = {rem_numerator[2], rem_numerator[1:0]};
    if (!rem_divbyzero) begin
      rem_remainder = {rem_numerator[2], rem_numerator[1:0] % rem_denominator[1:0]};
    end
    if (corrupt) begin
      rem_remainder[1:0] = rem_remainder[1:0] + 2'b01;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one word and wait (bounded) for the handshake edge.
  task automatic applyStimulus(input logic [2:0] word);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = word;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("[TB] FAIL handshake_timeout: observed in_ready=0 expected in_ready=1");
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic sendOp(input logic [2:0] num, input logic [2:0] den);
    applyStimulus(num);
    applyStimulus(den);
  endtask

  task automatic drainResult();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    corrupt  = 1'b0;
    rst      = 1'b1;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 3'b000;
    out_ready = 1'b0;

    step();
    step();
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_dbz_count", dbz_count, 0);
    checkOutput("rst_num", rem_numerator, 0);
    checkOutput("rst_remainder", out_remainder, 0);
    checkOutput("rst_selfcheck", selfcheck_err, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);

    // Basic: 7 / 2
    sendOp(3'b111, 3'b010);
    checkOutput("basic_eval_no_valid", out_valid, 0);
    checkOutput("basic_eval_in_ready", in_ready, 0);
    checkOutput("basic_num", rem_numerator, 3'b111);
    checkOutput("basic_den", rem_denominator, 3'b010);
    step();
    checkOutput("basic_out_valid", out_valid, 1);
    checkOutput("basic_rem_lo", out_remainder[1:0], 2'b01);
    checkOutput("basic_dbz_flag", out_divbyzero, 0);
    checkOutput("basic_dbz_count", dbz_count, 0);
    drainResult();
    checkOutput("basic_drained", out_valid, 0);
    checkOutput("basic_back_in_ready", in_ready, 1);

    // Divide-by-zero: 5 / 4
    sendOp(3'b101, 3'b100);
    step();
    checkOutput("dbz_out_valid", out_valid, 1);
    checkOutput("dbz_flag", out_divbyzero, 1);
    checkOutput("dbz_rem_msb", out_remainder[2], 1);
    checkOutput("dbz_count_1", dbz_count, 1);

    // Backpressure with in_valid asserted
    in_valid = 1'b1;
    in_data  = 3'b011;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_remainder", out_remainder, 3'b101);
      checkOutput("bp_flag", out_divbyzero, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_num_held", rem_numerator, 3'b101);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("bp_release_in_ready", in_ready, 1);
    checkOutput("bp_release_out_valid", out_valid, 0);
    checkOutput("bp_num_not_taken", rem_numerator, 3'b101);
    checkOutput("bp_den_not_taken", rem_denominator, 3'b100);

    // Abort in S_DEN
    applyStimulus(3'b110);
    checkOutput("abort_num_taken", rem_numerator, 3'b110);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_dbz_count", dbz_count, 1);
    sendOp(3'b011, 3'b010);
    step();
    checkOutput("post_abort_out_valid", out_valid, 1);
    checkOutput("post_abort_rem_lo", out_remainder[1:0], 2'b01);
    checkOutput("post_abort_num", rem_numerator, 3'b011);
    drainResult();

    // Abort in S_EVAL suppresses capture and count
    sendOp(3'b001, 3'b000);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("eval_abort_out_valid", out_valid, 0);
    checkOutput("eval_abort_dbz_count", dbz_count, 1);
    checkOutput("eval_abort_flag_kept", out_divbyzero, 0);
    checkOutput("eval_abort_rem_kept", out_remainder, 3'b001);
    checkOutput("eval_abort_in_ready", in_ready, 1);

    // Saturation: 16 more divide-by-zero ops (17 total)
    expCount = 1;
    for (int i = 0; i < 16; i++) begin
      sendOp(3'b010 + 3'(i % 2), (i % 2 == 0) ? 3'b000 : 3'b100);
      step();
      if (expCount < 15) expCount++;
      checkOutput("sat_out_valid", out_valid, 1);
      checkOutput("sat_count", dbz_count, expCount);
      drainResult();
    end
    checkOutput("sat_final_15", dbz_count, 15);

    // Reset in S_OUT
    sendOp(3'b111, 3'b011);
    step();
    checkOutput("rst_mid_out_valid_before", out_valid, 1);
    rst = 1'b1;
    step();
    checkOutput("rst_mid_out_valid", out_valid, 0);
    checkOutput("rst_mid_dbz_count", dbz_count, 0);
    checkOutput("rst_mid_num", rem_numerator, 0);
    checkOutput("rst_mid_den", rem_denominator, 0);
    checkOutput("rst_mid_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_in_ready_after", in_ready, 1);

`ifdef REM_SELFCHECK_EN
    corrupt = 1'b1;
    sendOp(3'b011, 3'b010);
    step();
    corrupt = 1'b0;
    checkOutput("selfcheck_set", selfcheck_err, 1);
    drainResult();
    sendOp(3'b110, 3'b011);
    step();
    checkOutput("selfcheck_sticky", selfcheck_err, 1);
    drainResult();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("selfcheck_cleared", selfcheck_err, 0);
`else
    sendOp(3'b011, 3'b010);
    step();
    corrupt = 1'b0;
    checkOutput("selfcheck_tied_low", selfcheck_err, 0);
    checkOutput("final_rem_lo", out_remainder[1:0], 2'b01);
    drainResult();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
